// File: rtl/uart_wb_bridge_if.sv
// Bundles the UART byte stream and the Wishbone classic bus seen by the bridge.
//   master : bridge view (consumes rx bytes, issues tx bytes, drives the bus)
//   slave  : peer view (UART + Wishbone slave side)
// Signals:
//   rx_data[7:0], rx_avail, rx_error -> bridge ; rx_ack <- bridge
//   tx_data[7:0], tx_wr <- bridge ; tx_busy -> bridge
//   wb_adr_o[31:0], wb_dat_o[31:0], wb_sel_o[3:0], wb_we_o, wb_cyc_o, wb_stb_o <- bridge
//   wb_dat_i[31:0], wb_ack_i -> bridge
interface uart_wb_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_error;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        input  rx_data, rx_avail, rx_error, tx_busy, wb_dat_i, wb_ack_i,
        output rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o,
               wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output rx_data, rx_avail, rx_error, tx_busy, wb_dat_i, wb_ack_i,
        input  rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o,
               wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone bridge. Parses 'W' adr[4] dat[4] and 'R' adr[4] commands
// (MSB first) from a byte stream, runs one Wishbone classic cycle with a
// TIMEOUT-cycle limit, and answers with 0x2E (write ok), four read bytes
// (MSB first) or 0xEE (timeout).
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : uart_wb_bridge_if.master (UART byte stream + Wishbone master)
//
// state | meaning
// IDLE  | waiting for a 'W'/'R' command byte, other bytes dropped
// ADDR  | collecting 4 address bytes
// DATA  | collecting 4 write-data bytes
// BUS   | Wishbone cycle in progress, timeout counter running
// RESP  | sending response byte(s) to the UART
module uart_wb_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_wb_bridge_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0]  CMD_W    = 8'h57;
    localparam logic [7:0]  CMD_R    = 8'h52;
    localparam logic [7:0]  RSP_OK   = 8'h2E;
    localparam logic [7:0]  RSP_TMO  = 8'hEE;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic        r_is_wr;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rdata;
    logic [15:0] r_tmo_cnt;
    logic        r_tmo_flag;
    logic        r_rx_ack;
    logic        r_tx_wr;
    logic [7:0]  r_tx_data;
    logic        r_cyc;
    logic        r_we;
    logic [3:0]  r_sel;

    logic        w_rx_state;
    logic        w_rx_take;
    logic        w_tx_go;
    logic        w_resp_last;
    logic [7:0]  w_resp_byte;

    // A set r_rx_ack masks the cycle right after a consume, while the UART
    // is still retiring the byte it was just told to drop.
    assign w_rx_state  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_rx_take   = w_rx_state && !r_rx_ack && (bus.rx_avail || bus.rx_error);
    assign w_tx_go     = !r_tx_wr && !bus.tx_busy;
    assign w_resp_last = r_tmo_flag || r_is_wr || (r_byte_cnt == 2'd3);

    always_comb begin
        w_resp_byte = RSP_TMO;
        if (!r_tmo_flag) begin
            if (r_is_wr) begin
                w_resp_byte = RSP_OK;
            end else begin
                case (r_byte_cnt)
                    2'd0:    w_resp_byte = r_rdata[31:24];
                    2'd1:    w_resp_byte = r_rdata[23:16];
                    2'd2:    w_resp_byte = r_rdata[15:8];
                    default: w_resp_byte = r_rdata[7:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_is_wr    <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_adr      <= 32'd0;
            r_dat      <= 32'd0;
            r_rdata    <= 32'd0;
            r_tmo_cnt  <= 16'd0;
            r_tmo_flag <= 1'b0;
            r_rx_ack   <= 1'b0;
            r_tx_wr    <= 1'b0;
            r_tx_data  <= 8'd0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'd0;
        end else begin
            r_rx_ack <= 1'b0;
            r_tx_wr  <= 1'b0;
            case (r_state)
                S_IDLE, S_ADDR, S_DATA: begin
                    if (w_rx_take) begin
                        r_rx_ack <= 1'b1;
                        if (bus.rx_error) begin
                            // error wins over a simultaneous byte
                            r_state    <= S_IDLE;
                            r_byte_cnt <= 2'd0;
                        end else if (r_state == S_IDLE) begin
                            if (bus.rx_data == CMD_W || bus.rx_data == CMD_R) begin
                                r_is_wr    <= (bus.rx_data == CMD_W);
                                r_byte_cnt <= 2'd0;
                                r_state    <= S_ADDR;
                            end
                        end else if (r_state == S_ADDR) begin
                            r_adr      <= {r_adr[23:0], bus.rx_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                if (r_is_wr) begin
                                    r_state <= S_DATA;
                                end else begin
                                    r_state    <= S_BUS;
                                    r_cyc      <= 1'b1;
                                    r_we       <= 1'b0;
                                    r_sel      <= 4'hF;
                                    r_tmo_cnt  <= 16'd0;
                                    r_tmo_flag <= 1'b0;
                                end
                            end
                        end else begin
                            r_dat      <= {r_dat[23:0], bus.rx_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_state    <= S_BUS;
                                r_cyc      <= 1'b1;
                                r_we       <= 1'b1;
                                r_sel      <= 4'hF;
                                r_tmo_cnt  <= 16'd0;
                                r_tmo_flag <= 1'b0;
                            end
                        end
                    end
                end
                S_BUS: begin
                    if (bus.wb_ack_i) begin
                        r_cyc      <= 1'b0;
                        r_we       <= 1'b0;
                        r_sel      <= 4'd0;
                        r_byte_cnt <= 2'd0;
                        r_state    <= S_RESP;
                        if (!r_is_wr) begin
                            r_rdata <= bus.wb_dat_i;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_cyc      <= 1'b0;
                        r_we       <= 1'b0;
                        r_sel      <= 4'd0;
                        r_byte_cnt <= 2'd0;
                        r_tmo_flag <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (w_tx_go) begin
                        r_tx_wr    <= 1'b1;
                        r_tx_data  <= w_resp_byte;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_resp_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ack   = r_rx_ack;
    assign bus.tx_wr    = r_tx_wr;
    assign bus.tx_data  = r_tx_data;
    assign bus.wb_cyc_o = r_cyc;
    assign bus.wb_stb_o = r_cyc;
    assign bus.wb_we_o  = r_we;
    assign bus.wb_sel_o = r_sel;
    assign bus.wb_adr_o = r_adr;
    assign bus.wb_dat_o = r_dat;
endmodule

// File: tb/tb_uart_wb_bridge.sv
module tb_uart_wb_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_wb_bridge_if u_if();

    uart_wb_bridge #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   n_ack = 0;
    int   n_bus = 0;
    logic cyc_d = 1'b0;

    always @(negedge clk) begin
        if (u_if.rx_ack) n_ack <= n_ack + 1;
        if (u_if.wb_cyc_o && !cyc_d) n_bus <= n_bus + 1;
        cyc_d <= u_if.wb_cyc_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic avail, input logic err);
        logic got;
        got = 1'b0;
        @(negedge clk);
        u_if.rx_data  = b;
        u_if.rx_avail = avail;
        u_if.rx_error = err;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (u_if.rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("rx_ack_seen", {31'd0, got}, 32'd1);
        u_if.rx_avail = 1'b0;
        u_if.rx_error = 1'b0;
    endtask

    task automatic send_seq(input logic [71:0] v, input int n);
        for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8], 1'b1, 1'b0);
    endtask

    task automatic wait_cyc();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (u_if.wb_cyc_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("cyc_start", {31'd0, got}, 32'd1);
    endtask

    // hold > 0 models a UART that stays busy after each strobe
    task automatic recv(input logic [7:0] exp, input string tag, input int hold);
        logic got;
        logic bad;
        got = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (u_if.tx_wr) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_wr"}, {31'd0, got}, 32'd1);
        chk(tag, {24'd0, u_if.tx_data}, {24'd0, exp});
        chk({tag, "_busy"}, {31'd0, u_if.tx_busy}, 32'd0);
        if (hold > 0) begin
            u_if.tx_busy = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (u_if.tx_wr) bad = 1'b1;
            end
            u_if.tx_busy = 1'b0;
            chk({tag, "_quiet_busy"}, {31'd0, bad}, 32'd0);
        end
    endtask

    task automatic quiet(input int n, input string tag);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (u_if.tx_wr || u_if.wb_cyc_o) bad = 1'b1;
        end
        chk(tag, {31'd0, bad}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"},  {31'd0, u_if.wb_cyc_o}, 32'd0);
        chk({tag, "_stb"},  {31'd0, u_if.wb_stb_o}, 32'd0);
        chk({tag, "_we"},   {31'd0, u_if.wb_we_o},  32'd0);
        chk({tag, "_sel"},  {28'd0, u_if.wb_sel_o}, 32'd0);
        chk({tag, "_adr"},  u_if.wb_adr_o, 32'd0);
        chk({tag, "_dat"},  u_if.wb_dat_o, 32'd0);
        chk({tag, "_rxack"}, {31'd0, u_if.rx_ack}, 32'd0);
        chk({tag, "_txwr"}, {31'd0, u_if.tx_wr}, 32'd0);
        chk({tag, "_txdat"}, {24'd0, u_if.tx_data}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_ack;
        int snap_bus;
        int cnt;
        logic got;

        u_if.rx_data  = 8'd0;
        u_if.rx_avail = 1'b0;
        u_if.rx_error = 1'b0;
        u_if.tx_busy  = 1'b0;
        u_if.wb_dat_i = 32'd0;
        u_if.wb_ack_i = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        reset_n = 1'b1;
        quiet(3, "idle_after_reset");

        // write, ack in first bus cycle
        send_seq(72'h57_00_00_10_04_DE_AD_BE_EF, 9);
        wait_cyc();
        chk("wr_adr", u_if.wb_adr_o, 32'h0000_1004);
        chk("wr_dat", u_if.wb_dat_o, 32'hDEAD_BEEF);
        chk("wr_we",  {31'd0, u_if.wb_we_o}, 32'd1);
        chk("wr_stb", {31'd0, u_if.wb_stb_o}, 32'd1);
        chk("wr_sel", {28'd0, u_if.wb_sel_o}, 32'hF);
        u_if.wb_ack_i = 1'b1;
        @(negedge clk);
        u_if.wb_ack_i = 1'b0;
        chk("wr_cyc_drop", {31'd0, u_if.wb_cyc_o}, 32'd0);
        chk("wr_stb_drop", {31'd0, u_if.wb_stb_o}, 32'd0);
        recv(8'h2E, "wr_resp", 3);
        quiet(5, "wr_done");

        // read, ack in third bus cycle; an rx_error raised mid-bus must wait for IDLE
        send_seq(72'h52_00_00_00_20, 5);
        wait_cyc();
        chk("rd_adr", u_if.wb_adr_o, 32'h0000_0020);
        chk("rd_we",  {31'd0, u_if.wb_we_o}, 32'd0);
        chk("rd_sel", {28'd0, u_if.wb_sel_o}, 32'hF);
        @(negedge clk);
        snap_ack = n_ack;
        u_if.rx_error = 1'b1;
        chk("rd_adr_hold1", u_if.wb_adr_o, 32'h0000_0020);
        @(negedge clk);
        chk("rd_adr_hold2", u_if.wb_adr_o, 32'h0000_0020);
        chk("rd_cyc_wait", {31'd0, u_if.wb_cyc_o}, 32'd1);
        u_if.wb_ack_i = 1'b1;
        u_if.wb_dat_i = 32'h1234_5678;
        @(negedge clk);
        u_if.wb_ack_i = 1'b0;
        u_if.wb_dat_i = 32'h0;
        chk("rd_cyc_drop", {31'd0, u_if.wb_cyc_o}, 32'd0);
        recv(8'h12, "rd_b0", 3);
        recv(8'h34, "rd_b1", 2);
        recv(8'h56, "rd_b2", 4);
        chk("err_held_in_resp", n_ack, snap_ack);
        recv(8'h78, "rd_b3", 0);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (u_if.rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        u_if.rx_error = 1'b0;
        chk("err_acked_in_idle", {31'd0, got}, 32'd1);
        quiet(4, "err_no_resp");
        chk("err_ack_once", n_ack, snap_ack + 1);

        // timeout on a read, late ack ignored
        snap_bus = n_bus;
        send_seq(72'h52_00_00_00_40, 5);
        wait_cyc();
        cnt = 0;
        while (u_if.wb_cyc_o && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cycles", cnt, 32'd16);
        chk("tmo_stb_drop", {31'd0, u_if.wb_stb_o}, 32'd0);
        recv(8'hEE, "tmo_resp", 2);
        u_if.wb_ack_i = 1'b1;
        u_if.wb_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        u_if.wb_ack_i = 1'b0;
        u_if.wb_dat_i = 32'h0;
        quiet(6, "late_ack_ignored");
        chk("tmo_bus_count", n_bus, snap_bus + 1);

        // abort a partial write with simultaneous byte+error, then a clean read
        snap_bus = n_bus;
        send(8'h57, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b1);
        quiet(4, "abort_quiet");
        chk("abort_no_bus", n_bus, snap_bus);
        send_seq(72'h52_00_00_00_00, 5);
        wait_cyc();
        chk("abort_rd_adr", u_if.wb_adr_o, 32'h0);
        chk("abort_rd_we", {31'd0, u_if.wb_we_o}, 32'd0);
        u_if.wb_ack_i = 1'b1;
        u_if.wb_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        u_if.wb_ack_i = 1'b0;
        u_if.wb_dat_i = 32'h0;
        recv(8'hCA, "ab_b0", 1);
        recv(8'hFE, "ab_b1", 1);
        recv(8'hF0, "ab_b2", 1);
        recv(8'h0D, "ab_b3", 1);
        quiet(3, "abort_done");

        // garbage bytes before a command
        snap_ack = n_ack;
        snap_bus = n_bus;
        send_seq(72'h41_FF_52_00_00_00_08, 7);
        wait_cyc();
        chk("gb_adr", u_if.wb_adr_o, 32'h0000_0008);
        chk("gb_we", {31'd0, u_if.wb_we_o}, 32'd0);
        u_if.wb_ack_i = 1'b1;
        u_if.wb_dat_i = 32'hA5C3_9617;
        @(negedge clk);
        u_if.wb_ack_i = 1'b0;
        u_if.wb_dat_i = 32'h0;
        recv(8'hA5, "gb_b0", 1);
        recv(8'hC3, "gb_b1", 1);
        recv(8'h96, "gb_b2", 1);
        recv(8'h17, "gb_b3", 1);
        quiet(3, "gb_done");
        chk("gb_acks", n_ack, snap_ack + 7);
        chk("gb_bus_count", n_bus, snap_bus + 1);

        // reset in the middle of a write cycle
        send_seq(72'h57_00_00_00_0C_11_22_33_44, 9);
        wait_cyc();
        chk("mid_cyc_up", {31'd0, u_if.wb_cyc_o}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_hold");
        reset_n = 1'b1;
        quiet(4, "post_reset_idle");
        send_seq(72'h52_00_00_00_04, 5);
        wait_cyc();
        chk("pr_adr", u_if.wb_adr_o, 32'h0000_0004);
        u_if.wb_ack_i = 1'b1;
        u_if.wb_dat_i = 32'h0102_0304;
        @(negedge clk);
        u_if.wb_ack_i = 1'b0;
        u_if.wb_dat_i = 32'h0;
        recv(8'h01, "pr_b0", 1);
        recv(8'h02, "pr_b1", 1);
        recv(8'h03, "pr_b2", 1);
        recv(8'h04, "pr_b3", 1);
        quiet(3, "pr_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL set the maximum Wishbone wait in clk cycles (range 1..65535).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Port rx_data  input  8  SHALL carry the received byte from the UART.
REQ-005 Port rx_avail  input  1  SHALL indicate that rx_data is valid.
REQ-006 Port rx_error  input  1  SHALL indicate a framing error on the last received byte.
REQ-007 Port rx_ack  output  1  SHALL be a one-cycle pulse that consumes the byte or error.
REQ-008 Port tx_data  output  8  SHALL carry the response byte to the UART.
REQ-009 Port tx_wr  output  1  SHALL be a one-cycle transmit strobe.
REQ-010 Port tx_busy  input  1  SHALL indicate that the UART transmitter is occupied.
REQ-011 Ports wb_adr_o  output  32, wb_dat_o  output  32, wb_dat_i  input  32, wb_sel_o  output  4, wb_we_o  output  1, wb_cyc_o  output  1, wb_stb_o  output  1, wb_ack_i  input  1 SHALL form a Wishbone classic single-cycle master.

Function
REQ-012 Command format: 0x57 'W' followed by 4 address bytes then 4 data bytes; 0x52 'R' followed by 4 address bytes; all multi-byte fields are MSB first.
REQ-013 FSM states SHALL be IDLE, ADDR, DATA, BUS, RESP.
- IDLE: 'W' or 'R' -> ADDR; any other byte is consumed and ignored.
- ADDR: after the 4th address byte, go to DATA for W or BUS for R.
- DATA: after the 4th data byte -> BUS.
- BUS -> RESP on ack or timeout.
- RESP -> IDLE after the last response byte is written.
REQ-014 Byte consumption: when rx_avail=1 and the FSM is in IDLE, ADDR or DATA, the block SHALL pulse rx_ack for exactly one cycle and SHALL ignore rx_avail in the following cycle, so no byte is consumed twice.
REQ-015 In BUS and RESP, rx_avail SHALL be left unacknowledged; the byte is held for later.
REQ-016 Address and data SHALL be assembled by left-shifting 8 bits per byte into 32-bit registers.
REQ-017 On entry to BUS, in the same cycle:
- wb_cyc_o=wb_stb_o=1;
- wb_we_o=1 for W, 0 for R;
- wb_sel_o=4'hF;
- wb_adr_o and wb_dat_o are held constant until the cycle ends.
REQ-018 On wb_ack_i=1 in BUS, the block SHALL:
- deassert cyc/stb on the next edge;
- latch wb_dat_i for R.
A combinational ack in the first BUS cycle SHALL be accepted.
REQ-019 Timeout: a 16-bit counter SHALL clear on BUS entry. If no ack arrives within TIMEOUT cycles, the block SHALL drop cyc/stb and set the timeout flag. An ack arriving later SHALL be ignored.
REQ-020 Response bytes:
- W success: single byte 0x2E.
- R success: 4 data bytes, MSB first.
- Any timeout: single byte 0xEE.
REQ-021 Transmit handshake: tx_wr SHALL pulse only when tx_busy=0 and tx_wr was 0 in the previous cycle; tx_data SHALL be stable while tx_wr=1.
REQ-022 rx_error=1 in any receive state (IDLE, ADDR, DATA) SHALL pulse rx_ack, discard the partial command and return to IDLE without a response.
REQ-023 rx_error=1 in BUS or RESP SHALL be left pending until IDLE, then acknowledged and discarded.
REQ-024 Simultaneous rx_avail=1 and rx_error=1 SHALL be handled as an error, per REQ-022.

Reset
REQ-025 While reset_n=0, independent of clk, the block SHALL hold:
- FSM=IDLE;
- rx_ack=0, tx_wr=0, tx_data=0;
- wb_cyc_o=wb_stb_o=wb_we_o=0;
- wb_sel_o=0, wb_adr_o=0, wb_dat_o=0;
- byte counter, timeout counter and flag cleared.
REQ-026 Reset asserted mid-bus-cycle SHALL drop cyc/stb immediately. After release, the block SHALL await a new command byte.

Verification
REQ-027 Write: bytes 57 00 00 10 04 DE AD BE EF -> one bus cycle with adr=0x00001004, dat=0xDEADBEEF, we=1, sel=F; after ack, tx byte 0x2E.
REQ-028 Read: bytes 52 00 00 00 20, slave acks after 3 cycles with 0x12345678 -> we=0; tx bytes 12 34 56 78 in order, each tx_wr issued only with tx_busy=0.
REQ-029 Timeout: TIMEOUT=16, R command, slave never acks -> cyc drops at 16 cycles; tx 0xEE; a late ack causes no change.
REQ-030 Error abort: 57 00 00 then rx_error=1 -> rx_ack pulse, no bus cycle; then 52 00 00 00 00 completes a normal read.
REQ-031 Garbage: bytes 41 FF 52 00 00 00 08 -> 0x41 and 0xFF are ignored; exactly one read of 0x00000008 occurs; every byte is acked exactly once.
REQ-032 Reset: reset_n low during BUS -> cyc/stb fall asynchronously; all outputs hold their REQ-025 values.
